spi_flash_reader: RTL
=====================

# spi_flash_reader

Single-read SPI flash master that turns a 24-bit word-read request into one SPI mode-0 transaction (8-bit command, 24-bit address, 32 data bits) against an external serial NOR flash and returns the 32-bit word. It sits between the SoC boot/XIP fetch logic and the flash pins. In simulation it drives the MT25Q-compatible flash model directly.

## Interface
- READ_CMD, 8'h03: command byte sent first, MSB first.
- CLK_DIV, 2: SCLK half-period in io_clk cycles; legal 1..255.
- CS_IDLE, 4: minimum io_clk cycles io_spi_ss stays high between transactions and after reset; legal 1..255.

Ports:
- io_clk  in  1  system clock; all logic on rising edge.
- io_rst_n  in  1  asynchronous, active-low reset.
- io_req_valid  in  1  read request.
- io_req_ready  out  1  block idle, request accepted when valid&&ready.
- io_req_address  in  24  flash byte address, captured on acceptance.
- io_rsp_valid  out  1  one-cycle pulse, io_rsp_data valid.
- io_rsp_data  out  32  read word, held until next acceptance.
- io_spi_sclk  out  1  serial clock, idles low.
- io_spi_mosi  out  1  serial data to flash.
- io_spi_miso  in  1  serial data from flash.
- io_spi_ss  out  1  chip select, active low (high = deselected).

## Operation
- All outputs registered. Reset values: io_spi_ss=1, io_spi_sclk=0, io_spi_mosi=0, io_req_ready=0, io_rsp_valid=0, io_rsp_data=0.
- States: GAP, IDLE, SELECT, SHIFT, DESELECT. Reset enters GAP.
- GAP: ss high, counts CS_IDLE cycles, then IDLE.
- IDLE: io_req_ready=1. On valid&&ready: latch 32-bit shift word {READ_CMD, address}, ready=0, then SELECT.
- SELECT: ss low, sclk low, mosi = shift word bit 31, for CLK_DIV cycles. Then SHIFT.
- SHIFT: 64 SCLK periods, each CLK_DIV high plus CLK_DIV low, controlled by a 7-bit bit counter.
  - Periods 1..32 transmit. The next mosi bit is driven in the cycle sclk falls.
  - Periods 33..64 receive. io_spi_miso is sampled in the cycle sclk is driven high.
  - mosi=0 during receive periods.
- Receive assembly:
  - Byte k (k=0..3) is received MSB first into io_rsp_data[8k+7:8k].
  - The first received bit lands in io_rsp_data[7]. The last received bit lands in io_rsp_data[24].
- DESELECT: after the 64th high phase, sclk low for CLK_DIV cycles. Then ss=1 and io_rsp_valid=1 for one cycle, io_rsp_data updated in that cycle, then GAP.
- No response backpressure; the consumer must take the data during the pulse or from the held register.
- Requests while ready=0 are ignored; the requester must hold valid.
- Reset asserted mid-transfer:
  - ss high and sclk/mosi low immediately (asynchronous).
  - No rsp_valid pulse; partial data discarded.
  - After release, GAP runs before ready rises.

## Timing
- Acceptance cycle = cycle 0. ss falls in cycle 1.
- Rising edge k of sclk: cycle 1+CLK_DIV+(k-1)*2*CLK_DIV.
- rsp_valid and ss rise in cycle 1+129*CLK_DIV (259 for CLK_DIV=2).
- io_req_ready rises CLK_DIV... precisely: CS_IDLE cycles after rsp_valid.
- After reset release, ready rises in cycle CS_IDLE (first cycle = 0).
- Back-to-back transactions: ss high for at least CS_IDLE+1 cycles.

## Test plan
- Reset held: ss=1, sclk=0, mosi=0, ready=0. Release: ready=1 exactly CS_IDLE cycles later.
- Request 24'h000004 with CLK_DIV=2:
  - mosi at the first 32 sclk rises = 8'h03 then 24'h000004, MSB first.
  - Flash model returns bytes 8'h11, 8'h22, 8'h33, 8'h44 in that order.
  - Expect io_rsp_data=32'h44332211 and rsp_valid in cycle 259.
- Two back-to-back requests (valid held high) to 24'h000000 and 24'h000008:
  - Two correct responses.
  - ss high at least CS_IDLE+1 cycles between transactions.
  - Exactly 64 sclk rises per transaction.
- CLK_DIV=1, READ_CMD=8'h0B:
  - Command bits 8'h0B observed on mosi.
  - rsp_valid in cycle 130.
  - sclk 50% duty.
- io_rst_n pulsed low during SHIFT period 40:
  - ss high same cycle, no rsp_valid.
  - Next request after recovery returns the correct word.
- io_req_valid asserted while busy, with address changed mid-transfer:
  - The transfer uses the originally captured address.
  - The second request is accepted only once ready=1.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-word SPI mode-0 read master for a serial NOR flash.
// Sends {READ_CMD, 24-bit address}, then clocks in 32 data bits and returns
// them with the first received byte in the least significant byte lane.
module spi_flash_reader #(
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic        io_clk,
  input  logic        io_rst_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [23:0] io_req_address,
  output logic        io_rsp_valid,
  output logic [31:0] io_rsp_data,
  output logic        io_spi_sclk,
  output logic        io_spi_mosi,
  input  logic        io_spi_miso,
  output logic        io_spi_ss
);

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    SELECT,
    SHIFT,
    DESELECT
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);
  localparam logic [6:0] LAST_BIT = 7'd63;
  localparam logic [6:0] RX_FIRST = 7'd32;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        ss_q, ss_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // State and registered outputs; reset deselects the flash immediately.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q     <= GAP;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ss_d        = ss_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      GAP: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      IDLE: begin
        if (io_req_valid && ready_q) begin
          tx_d    = {READ_CMD, io_req_address};
          rx_d    = '0;
          ready_d = 1'b0;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = READ_CMD[7];
          cnt_d   = '0;
          state_d = SELECT;
        end
      end

      SELECT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              mosi_d  = 1'b0;
              state_d = DESELECT;
            end else begin
              // tx drains to zero after 32 shifts, so mosi stays low while receiving
              mosi_d = tx_q[30];
              tx_d   = {tx_q[30:0], 1'b0};
              bit_d  = bit_q + 7'd1;
            end
          end else begin
            sclk_d = 1'b1;
            if (bit_q >= RX_FIRST) begin
              rx_d = {rx_q[30:0], io_spi_miso};
            end
          end
        end
      end

      DESELECT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d       = '0;
          ss_d        = 1'b1;
          rsp_valid_d = 1'b1;
          // first byte on the wire sits in the top of rx; swap into lane 0
          rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = GAP;
    endcase
  end

  assign io_req_ready = ready_q;
  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_data  = rsp_data_q;
  assign io_spi_sclk  = sclk_q;
  assign io_spi_mosi  = mosi_q;
  assign io_spi_ss    = ss_q;

endmodule
